// File: rtl/codificador_prioridade_rr.sv
// Registered N-input priority encoder with valid/ready output stage.
// Fixed mode grants the highest set index; round-robin searches upward from ptr.
module codificador_prioridade_rr #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         modo,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] code,
  output logic         out_multi
);

  typedef enum logic {VAZIO = 1'b0, CHEIO = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   code_q, code_d;
  logic           multi_q, multi_d;
  logic [W-1:0]   ptr_q, ptr_d;

  logic           accept, load;
  logic [W-1:0]   ptr_nxt, ptr_eff;
  logic [W-1:0]   fix_code, rr_code;
  logic [N-1:0]   rr_hi, rr_src;
  logic           multi;

  assign out_valid = (state_q == CHEIO);
  assign code      = code_q;
  assign out_multi = multi_q;

  assign accept  = out_valid && out_ready;
  assign load    = (!out_valid || out_ready) && (req != '0);
  assign ptr_nxt = (code_q == W'(N - 1)) ? '0 : code_q + W'(1);
  // Use the pointer implied by the transfer completing this edge so
  // back-to-back grants stay fair without a bubble.
  assign ptr_eff = accept ? ptr_nxt : ptr_q;
  assign multi   = |(req & (req - N'(1)));

  always_comb begin
    fix_code = '0;
    for (int i = 0; i < N; i++)
      if (req[i]) fix_code = W'(i);
  end

  // Lowest set bit at or above ptr_eff, else lowest set bit overall (wrap).
  always_comb begin
    rr_hi   = req & ~((N'(1) << ptr_eff) - N'(1));
    rr_src  = (rr_hi != '0) ? rr_hi : req;
    rr_code = '0;
    for (int i = N - 1; i >= 0; i--)
      if (rr_src[i]) rr_code = W'(i);
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    multi_d = multi_q;
    ptr_d   = ptr_q;
    if (accept) ptr_d = ptr_nxt;
    case (state_q)
      VAZIO:   if (load) state_d = CHEIO;
      CHEIO:   if (out_ready) state_d = (req != '0) ? CHEIO : VAZIO;
      default: state_d = VAZIO;
    endcase
    if (load) begin
      code_d  = modo ? rr_code : fix_code;
      multi_d = multi;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= VAZIO;
      code_q  <= '0;
      multi_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      multi_q <= multi_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_codificador_prioridade_rr.sv
// Scoreboard bench: stimulus pushes expected transfers, monitors pop on accept.
module tb_codificador_prioridade_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] req8;
  logic       modo8, rdy8, ov8, multi8;
  logic [2:0] code8;
  logic [4:0] req5;
  logic       modo5, rdy5, ov5, multi5;
  logic [2:0] code5;

  codificador_prioridade_rr #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .req(req8), .modo(modo8), .out_ready(rdy8),
    .out_valid(ov8), .code(code8), .out_multi(multi8)
  );

  codificador_prioridade_rr #(.N(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .req(req5), .modo(modo5), .out_ready(rdy5),
    .out_valid(ov5), .code(code5), .out_multi(multi5)
  );

  typedef struct packed {
    logic [2:0] code;
    logic       multi;
  } exp_t;

  exp_t q8[$];
  exp_t q5[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push8(input int c, input int m);
    q8.push_back('{code: 3'(c), multi: 1'(m)});
  endtask

  task automatic push5(input int c, input int m);
    q5.push_back('{code: 3'(c), multi: 1'(m)});
  endtask

  task automatic mon8();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && ov8 && rdy8) begin
        if (q8.size() == 0) begin
          checks++; errors++;
          $display("FAIL mon8_unexpected: got code %0d, expected no transfer", code8);
        end else begin
          e = q8.pop_front();
          check("mon8_code", int'(code8), int'(e.code));
          check("mon8_multi", int'(multi8), int'(e.multi));
        end
      end
    end
  endtask

  task automatic mon5();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && ov5 && rdy5) begin
        check("mon5_range", int'(code5 < 3'd5), 1);
        if (q5.size() == 0) begin
          checks++; errors++;
          $display("FAIL mon5_unexpected: got code %0d, expected no transfer", code5);
        end else begin
          e = q5.pop_front();
          check("mon5_code", int'(code5), int'(e.code));
          check("mon5_multi", int'(multi5), int'(e.multi));
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    req8 = '0; modo8 = 1'b0; rdy8 = 1'b0;
    req5 = '0; modo5 = 1'b0; rdy5 = 1'b0;
    fork
      mon8();
      mon5();
    join_none

    // reset state
    repeat (2) step();
    check("rst_valid", int'(ov8), 0);
    check("rst_code", int'(code8), 0);
    check("rst_multi", int'(multi8), 0);

    // capture, then asynchronous reset between edges
    rst_n = 1'b1;
    req8 = 8'hFF;
    step();
    check("pre_rst_valid", int'(ov8), 1);
    check("pre_rst_code", int'(code8), 7);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", int'(ov8), 0);
    check("async_rst_code", int'(code8), 0);
    check("async_rst_multi", int'(multi8), 0);
    rst_n = 1'b1;
    step();
    check("post_rst_valid", int'(ov8), 1);
    check("post_rst_code", int'(code8), 7);
    check("post_rst_multi", int'(multi8), 1);

    // fixed priority
    push8(7, 1);
    rdy8 = 1'b1;
    req8 = 8'b0000_0101; push8(2, 1); step();
    req8 = 8'b0000_0001; push8(0, 0); step();
    req8 = 8'h00; step();
    check("drain_valid", int'(ov8), 0);
    check("drain_code_kept", int'(code8), 0);

    // round-robin fairness, ptr=1 after accepting code 0
    modo8 = 1'b1;
    req8 = 8'b1001_0010;
    push8(1, 1); push8(4, 1); push8(7, 1);
    push8(1, 1); push8(4, 1); push8(7, 1);
    for (int i = 0; i < 6; i++) begin
      step();
      check("rr_no_bubble", int'(ov8), 1);
    end
    req8 = 8'h00;
    step();
    check("rr_drain_valid", int'(ov8), 0);

    // backpressure
    modo8 = 1'b0; rdy8 = 1'b0;
    req8 = 8'h10;
    step();
    check("bp_capture_code", int'(code8), 4);
    push8(4, 0);
    req8 = 8'h80;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_code", int'(code8), 4);
      check("bp_hold_valid", int'(ov8), 1);
    end
    rdy8 = 1'b1;
    push8(7, 0);
    step();
    check("bp_release_code", int'(code8), 7);

    // wrap: accepting code 7 gives ptr 0, then round-robin
    modo8 = 1'b1;
    req8 = 8'b1000_0001;
    push8(0, 1); step();
    push8(7, 1); step();
    push8(0, 1); step();
    req8 = 8'h00;
    step();
    check("wrap_drain_valid", int'(ov8), 0);

    // odd width N=5
    modo5 = 1'b1; rdy5 = 1'b1;
    req5 = 5'b10001;
    push5(0, 1); step();
    push5(4, 1); step();
    push5(0, 1); step();
    req5 = 5'b00000;
    step();
    check("n5_drain_valid", int'(ov5), 0);

    repeat (2) step();
    check("q8_empty", q8.size(), 0);
    check("q5_empty", q5.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/codificador_prioridade_rr.md
# codificador_prioridade_rr

Registered N-input priority encoder with a valid/ready output stage and two arbitration modes: fixed priority (highest index wins) and round-robin. It is the parametrised, clocked successor to the team's 3-input combinational encoders. It sits between request sources (buttons, peripheral flags) and a consumer that takes one encoded index per transfer. A multi-request flag reports whether more than one request was active when the code was captured.

## Interface

Parameters:
- N, default 8 — number of request inputs; legal range 2..32.
- W, derived as $clog2(N) — width of the encoded index. It is a localparam and is not overridable.

Ports:
- clk  input  1  — system clock; all state changes on the rising edge.
- rst_n  input  1  — reset, asynchronous and active-low.
- req  input  N  — request vector; bit i requests index i; level-sensitive.
- modo  input  1  — 0 = fixed priority, 1 = round-robin.
- out_ready  input  1  — consumer accepts the output this cycle.
- out_valid  output  1  — code and out_multi hold a captured result.
- code  output  W  — encoded index of the granted request.
- out_multi  output  1  — more than one req bit was set at capture.

## Operation

- Reset (rst_n low, any time, including mid-transfer):
  - out_valid=0, code=0, out_multi=0.
  - Round-robin pointer ptr=0.
  - Reset takes effect immediately and does not wait for a clock edge.
- Load condition: load = (!out_valid || out_ready) && (req != 0).
  - On load, code, out_multi and out_valid=1 are registered from the current req and modo.
- Hold:
  - While out_valid=1 and out_ready=0, code and out_multi are frozen.
  - Changes on req or modo during hold are ignored.
- Drain: if out_valid=1, out_ready=1 and req==0, then out_valid goes to 0. code and out_multi keep their last value.
- Fixed mode (modo=0): the grant is the highest set index of req.
- Round-robin mode (modo=1):
  - Search ascending from ptr, wrapping N-1 to 0.
  - The first set bit wins.
- Pointer update:
  - On every accepted transfer (out_valid && out_ready), ptr is set to (code+1) mod N.
  - This happens in both modes, so switching to round-robin continues fairly.
  - Wrap-around: code=N-1 gives ptr=0.
- Simultaneous accept and load:
  - The new grant is computed with the pointer derived from the code being accepted this cycle, i.e. (code+1) mod N, not the stale ptr.
  - This allows back-to-back transfers with no bubble.
- out_multi is 1 when popcount(req) ≥ 2 at capture, independent of mode.
- Non-power-of-2 N: codes ≥ N are never produced.
- State machine, two states, encoded by out_valid:
  - VAZIO → CHEIO on load.
  - CHEIO → CHEIO on accept with req≠0 (reload).
  - CHEIO → VAZIO on accept with req==0.
  - CHEIO → CHEIO (hold) while out_ready=0.

## Timing

- Latency: req asserted before edge k gives out_valid=1 and code valid after edge k (one cycle).
- Throughput: one transfer per cycle while req≠0 and out_ready=1.
- out_ready has no combinational path to out_valid or code, and there is no path from req to any output. All outputs are registers.
- out_ready while out_valid=0 has no effect other than permitting load.
- modo is sampled only at the load edge.

## Test plan

- Reset: with req=8'hFF and out_ready=0, assert rst_n=0 between clock edges → outputs clear immediately: out_valid=0, code=0, out_multi=0. Release, then one edge → out_valid=1, code=7, out_multi=1.
- Fixed priority, N=8, modo=0, out_ready=1:
  - req=8'b0000_0101 → code=2, out_multi=1.
  - req=8'b0000_0001 → code=0, out_multi=0.
  - req=0 → out_valid drops after one accept.
- Round-robin fairness, modo=1, req=8'b1001_0010 held, out_ready=1 → codes 1,4,7,1,4,7 on consecutive cycles, with no bubble cycles.
- Backpressure, modo=0: capture with req=8'h10 (code=4), hold out_ready=0 for 5 cycles while req changes to 8'h80 → code stays 4. On out_ready=1 → code=7 on the next cycle.
- Wrap and mode switch:
  - modo=0, accept code=7 → ptr=0.
  - Switch to modo=1 with req=8'b1000_0001 → code=0, then 7, then 0.
- Odd width, N=5, modo=1, req=5'b10001 → codes 0,4,0. code never exceeds 4; out_multi=1 on each.
